// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU and loader share one Memoria port, CPU priority
// bounded by a starvation counter so a pending loader is eventually served.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        ld_req,
    input  logic        ld_wr,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ack,
    output logic [31:0] ld_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, DONE} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] ld_rdata_q, ld_rdata_d;
    logic        grant_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            lat_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            lat_q       <= lat_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req || ld_req) state_d = ACCESS;
            ACCESS:  state_d = (wr_q || lat_q == 2'd0) ? DONE : RD_WAIT;
            RD_WAIT: if (lat_q == 2'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The loader only wins a contested cycle once the CPU has used up its run.
    assign grant_ld = ld_req && (!cpu_req || starve_q == STARVE_LIM);

    always_comb begin
        starve_d    = starve_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        lat_d       = lat_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        if (state_q == IDLE && (cpu_req || ld_req)) begin
            owner_d     = grant_ld;
            wr_d        = grant_ld ? ld_wr : cpu_wr;
            mem_addr_d  = grant_ld ? ld_addr : cpu_addr;
            mem_wdata_d = grant_ld ? ld_wdata : cpu_wdata;
            lat_d       = LAT_INIT;
            if (grant_ld || !ld_req)
                starve_d = '0;
            else if (starve_q != STARVE_LIM)
                starve_d = starve_q + 4'd1;
        end else if ((state_q == ACCESS || state_q == RD_WAIT) && !wr_q) begin
            // lat_q counts the read cycles still to go after the current one.
            if (lat_q == 2'd0) begin
                if (owner_q) ld_rdata_d  = mem_rdata;
                else         cpu_rdata_d = mem_rdata;
            end else begin
                lat_d = lat_q - 2'd1;
            end
        end
    end

    always_comb begin
        mem_wr    = (state_q == ACCESS) && wr_q;
        busy      = (state_q != IDLE);
        cpu_ack   = (state_q == DONE) && !owner_q;
        ld_ack    = (state_q == DONE) && owner_q;
        owner     = owner_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        cpu_rdata = cpu_rdata_q;
        ld_rdata  = ld_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written
// starvation, held-request and mid-transaction reset sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        ld_req = 1'b0, ld_wr = 1'b0;
    logic [31:0] ld_addr = '0, ld_wdata = '0;
    logic        cpu_ack, ld_ack, mem_wr, busy, owner;
    logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cpu_rd = '0;
    logic [31:0] exp_ld_rd  = '0;

    typedef struct {
        logic        cr, lr, cw, lw;
        logic [31:0] ca, cd, la, ldd;
        logic        exp_owner;
        logic [31:0] exp_rd;
        int unsigned exp_lat;
    } vec_t;

    vec_t vecs [7];

    mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Small word-addressed memory standing in for Memoria.
    logic [31:0] mem_arr [16];
    assign mem_rdata = mem_arr[mem_addr[5:2]];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= 32'hA5A5_0000 + 32'(i);
            mem_arr[4] <= 32'hDEADBEEF;
        end else if (mem_wr) begin
            mem_arr[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge inside an IDLE cycle.
    task automatic run_vec(input vec_t v, input string tag);
        int unsigned ack_at = 0;
        int unsigned wr_cycles = 0;
        int unsigned cpu_acks = 0;
        int unsigned ld_acks = 0;
        logic [31:0] a_exp, d_exp;
        logic        w_exp;
        cpu_req = v.cr; cpu_wr = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        ld_req  = v.lr; ld_wr  = v.lw; ld_addr  = v.la; ld_wdata  = v.ldd;
        a_exp = v.exp_owner ? v.la : v.ca;
        d_exp = v.exp_owner ? v.ldd : v.cd;
        w_exp = v.exp_owner ? v.lw : v.cw;
        @(posedge clk);
        for (int unsigned n = 1; n <= 8 && ack_at == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk({tag, " owner"}, 32'(owner), 32'(v.exp_owner));
                chk({tag, " busy"}, 32'(busy), 32'd1);
                chk({tag, " mem_addr"}, mem_addr, a_exp);
                if (w_exp) chk({tag, " mem_wdata"}, mem_wdata, d_exp);
                cpu_addr  = cpu_addr ^ 32'hFFFF_0000;
                cpu_wdata = ~cpu_wdata;
                ld_addr   = ld_addr ^ 32'hFFFF_0000;
                ld_wdata  = ~ld_wdata;
            end
            if (mem_wr) wr_cycles++;
            if (cpu_ack) cpu_acks++;
            if (ld_ack) ld_acks++;
            if (cpu_ack || ld_ack) begin
                ack_at = n;
                chk({tag, " mem_addr_hold"}, mem_addr, a_exp);
            end
        end
        chk({tag, " latency"}, 32'(ack_at), 32'(v.exp_lat));
        chk({tag, " cpu_acks"}, 32'(cpu_acks), v.exp_owner ? 32'd0 : 32'd1);
        chk({tag, " ld_acks"}, 32'(ld_acks), v.exp_owner ? 32'd1 : 32'd0);
        chk({tag, " wr_cycles"}, 32'(wr_cycles), w_exp ? 32'd1 : 32'd0);
        if (!w_exp) begin
            if (v.exp_owner) exp_ld_rd = v.exp_rd;
            else             exp_cpu_rd = v.exp_rd;
        end
        chk({tag, " cpu_rdata"}, cpu_rdata, exp_cpu_rd);
        chk({tag, " ld_rdata"}, ld_rdata, exp_ld_rd);
        if (v.exp_owner) ld_req = 1'b0;
        else             cpu_req = 1'b0;
        cpu_addr = v.ca; cpu_wdata = v.cd; ld_addr = v.la; ld_wdata = v.ldd;
        @(negedge clk);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        chk({tag, " ack_pulse"}, {30'd0, cpu_ack, ld_ack}, 32'd0);
    endtask

    initial begin
        vec_t        rv;
        logic [5:0]  order;
        int unsigned grants, idle_run, acks, collide;
        logic        prev_busy, fin;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'h0,  32'h0,        1'b0, 32'hDEADBEEF, 3};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,        32'h20, 32'h12345678, 1'b1, 32'h0,        2};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h20, 32'h0,        1'b1, 32'h12345678, 3};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h14, 32'hCAFEF00D, 32'h0,  32'h0,        1'b0, 32'h0,        2};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 32'h0,        32'h0,  32'h0,        1'b0, 32'hCAFEF00D, 3};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0,        32'h10, 32'h0,        1'b0, 32'h12345678, 3};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 3};

        #2;
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst rdata", cpu_rdata | ld_rdata, 32'h0);
        chk("rst flags", {27'd0, mem_wr, cpu_ack, ld_ack, busy, owner}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Both held high: four CPU grants, then the loader, then CPU again.
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10;
        ld_req  = 1'b1; ld_wr  = 1'b0; ld_addr  = 32'h14;
        order = '0; grants = 0; idle_run = 0; acks = 0; collide = 0;
        prev_busy = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                if (grants < 6) order[grants] = owner;
                if (grants > 0) chk($sformatf("starve idle_gap%0d", grants), 32'(idle_run), 32'd1);
                grants++;
                idle_run = 0;
            end
            if (!busy) idle_run++;
            if (cpu_ack && ld_ack) collide++;
            if (cpu_ack || ld_ack) acks++;
            if (grants >= 6 && (cpu_ack || ld_ack)) begin
                cpu_req = 1'b0;
                ld_req  = 1'b0;
                fin = 1'b1;
            end
            prev_busy = busy;
        end
        chk("starve done", 32'(fin), 32'd1);
        chk("starve order", 32'(order), 32'h10);
        chk("starve acks", 32'(acks), 32'd6);
        chk("starve collide", 32'(collide), 32'd0);
        @(negedge clk);
        chk("starve idle", 32'(busy), 32'd0);

        // Reset in the middle of a write ACCESS cycle.
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h18; cpu_wdata = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        chk("abort pre mem_wr", 32'(mem_wr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort mem_wr", 32'(mem_wr), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ack", {30'd0, cpu_ack, ld_ack}, 32'd0);
        chk("abort rdata", cpu_rdata | ld_rdata, 32'h0);
        @(negedge clk);
        chk("abort held", {29'd0, busy, cpu_ack, ld_ack}, 32'd0);
        rst_n = 1'b1;
        exp_cpu_rd = '0;
        exp_ld_rd  = '0;
        rv = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h18, 32'h55AA55AA, 32'h0, 32'h0, 1'b0, 32'h0, 2};
        run_vec(rv, "post_rst_wr");
        rv = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h18, 32'h0, 32'h0, 32'h0, 1'b0, 32'h55AA55AA, 3};
        run_vec(rv, "post_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
